bcd_convert_seq: RTL
====================

Name: bcd_convert_seq

Overview:
Sequential binary-to-BCD converter that uses the shift-add-3 (double-dabble) method, one bit per clock. It sits directly downstream of the countdown timer. It consumes the timer's 10-bit count value and produces packed decimal digits for the per-digit seven-segment decoders. It replaces the fixed-range compare ladder with a general converter that covers the full input width and has a start/done handshake.

Parameters:
- BIN_W, 10, width of the binary input.
- DIGITS, 3, number of BCD output digits. Maximum representable value is 10^DIGITS-1.

Ports:
- clk  input  1  system clock
- resetn  input  1  asynchronous active-low reset
- start  input  1  request a conversion of bin_in; sampled on the rising edge of clk
- bin_in  input  BIN_W  unsigned binary value; captured on the accepted start edge only
- busy  output  1  high while a conversion is in progress
- done  output  1  one-cycle pulse when the bcd and ovf outputs update
- bcd  output  4*DIGITS  packed result; the least-significant digit is in [3:0]; holds the last result
- ovf  output  1  last captured input exceeded 10^DIGITS-1

Behaviour:
- Reset is asynchronous and active-low; clock is clk.
  - Reset values: busy=0, done=0, bcd=0, ovf=0, state=IDLE, shift register=0, bit counter=0.
- The FSM has three states: IDLE, SHIFT, FINISH.
- IDLE:
  - start=1 at edge E: capture bin_in into the shift register and clear the BCD accumulator.
  - At the same edge E, compute the ovf candidate as (bin_in > 10^DIGITS-1) and set bit counter = BIN_W.
  - At the same edge E, set busy=1 and go to SHIFT.
- SHIFT, one bit per edge:
  - Apply the adjust step to each accumulator digit: add 3 if the digit is ≥5.
  - Shift {accumulator, shift register} left by 1.
  - Decrement the counter.
  - When the counter reaches 1 on this edge, go to FINISH.
  - There are exactly BIN_W shift edges, E+1 through E+BIN_W.
- FINISH is entered after edge E+BIN_W and is resolved on edge E+BIN_W+1:
  - Load bcd from the accumulator, or load all digits = 9 if the ovf candidate is set.
  - Load ovf from the ovf candidate.
  - Set done=1, busy=0, and return to IDLE.
  - Latency: start sampled at edge E → done high in the cycle after edge E+BIN_W+1. That is 11 edges for the default BIN_W=10.
- done is high for exactly one cycle. It is cleared on the next edge unless a new conversion completes on that edge.
- bcd and ovf change only on the done edge. They hold stable across busy periods, so the display never shows partial sums.
- start while busy=1 is ignored. bin_in is not re-sampled.
- start in the cycle where done=1 is accepted, since the FSM is in IDLE. Back-to-back conversions therefore have a throughput of one per BIN_W+2 cycles.
- Input 0 converts to bcd=0, ovf=0.
- Input 10^DIGITS-1 converts to all 9s with ovf=0.
- Any larger input saturates to all 9s with ovf=1.
- Reset asserted mid-conversion immediately aborts the conversion. All outputs return to reset values and no done pulse is issued.
- Accumulator arithmetic: each digit is 4 bits. After the adjust step a digit can never exceed 15, so there is no carry between digits inside the adjust step. Carries between digits happen only through the shift.

Optional Feature:
- Macro: BCD_AUTO_CONVERT_EN.
- When defined:
  - The block keeps an internal register last_bin, reset to 0.
  - In IDLE it self-starts whenever bin_in != last_bin; it also still accepts start.
  - last_bin is updated at the accepted start edge. This lets the block track the timer count directly with no controller strobe.
- When not defined:
  - Conversions occur only on an external start.
  - last_bin and its comparator are not synthesised.

Decomposition:
- Shared package holds:
  - BCD_DIGIT_W=4
  - BCD_ADJ_THRESH=5
  - BCD_ADJ_ADD=3
  - the FSM state encoding: IDLE=2'd0, SHIFT=2'd1, FINISH=2'd2
- One natural sub-module, bcd_digit_adj: a purely combinational 4-bit add-3-if-≥5 stage, instantiated DIGITS times by a generate loop.
- All state stays in bcd_convert_seq.

Test Plan:
- Convert 60: start with bin_in=60 → done pulses 11 edges after start, bcd=12'h060, ovf=0, busy high for exactly 11 cycles.
- Boundary values:
  - bin_in=0 → bcd=12'h000, ovf=0.
  - bin_in=999 → bcd=12'h999, ovf=0.
  - bin_in=1023 → bcd=12'h999, ovf=1.
- Start while busy: start with bin_in=37, then pulse start with bin_in=500 at edge E+4 → a single done pulse, bcd=12'h037.
- Mid-conversion reset: start with bin_in=45, assert resetn=0 between edges E+5 and E+6 → busy, done and bcd drop to 0 immediately, and no done follows.
- Back-to-back and auto-convert:
  - Start with 59, then start with 58 asserted in the done cycle → a second done 11 edges later with bcd=12'h058.
  - With BCD_AUTO_CONVERT_EN defined, changing bin_in from 60 to 59 with start=0 → conversion begins and done yields bcd=12'h059.

Source files
------------

// File: rtl/bcd_convert_seq_pkg.sv
// Shared constants, FSM encoding and helpers for the sequential binary-to-BCD converter.
package bcd_convert_seq_pkg;

    localparam int unsigned BCD_DIGIT_W    = 4;
    localparam int unsigned BCD_ADJ_THRESH = 5;
    localparam int unsigned BCD_ADJ_ADD    = 3;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SHIFT  = 2'd1;
    localparam logic [1:0] FINISH = 2'd2;

    // Largest value representable with the given number of decimal digits.
    function automatic longint unsigned bcd_max_value(input int unsigned digits);
        longint unsigned v;
        v = 1;
        for (int unsigned i = 0; i < digits; i++) begin
            v = v * 10;
        end
        return v - 1;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Combinational double-dabble adjust stage: one BCD digit, add 3 when the digit is 5 or more.
module bcd_digit_adj
    import bcd_convert_seq_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit,
    output logic [BCD_DIGIT_W-1:0] adjusted
);

    always_comb begin
        adjusted = digit;
        if (digit >= BCD_DIGIT_W'(BCD_ADJ_THRESH)) begin
            adjusted = digit + BCD_DIGIT_W'(BCD_ADJ_ADD);
        end
    end

endmodule

// File: rtl/bcd_convert_seq.sv
// Sequential shift-add-3 binary-to-BCD converter, one input bit per clock, start/done handshake.
// Optional self-start on input change: define BCD_AUTO_CONVERT_EN.
module bcd_convert_seq
    import bcd_convert_seq_pkg::*;
#(
    parameter int unsigned BIN_W  = 10,
    parameter int unsigned DIGITS = 3
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          start,
    input  logic [BIN_W-1:0]              bin_in,
    output logic                          busy,
    output logic                          done,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
    output logic                          ovf
);

    localparam int unsigned ACC_W   = BCD_DIGIT_W * DIGITS;
    localparam int unsigned CNT_W   = $clog2(BIN_W + 1);
    localparam logic [63:0] MAX_VAL = 64'(bcd_max_value(DIGITS));

    logic [1:0]       state;
    logic [BIN_W-1:0] shreg;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_adj;
    logic [CNT_W-1:0] cnt;
    logic             ovf_cand;
    logic             over;
    logic             go;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit    (acc[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .adjusted (acc_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    assign over = 64'(bin_in) > MAX_VAL;

`ifdef BCD_AUTO_CONVERT_EN
    logic [BIN_W-1:0] last_bin;

    assign go = start || (bin_in != last_bin);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_bin <= '0;
        end else if (state == IDLE && go) begin
            last_bin <= bin_in;
        end
    end
`else
    assign go = start;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            shreg    <= '0;
            acc      <= '0;
            cnt      <= '0;
            ovf_cand <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            bcd      <= '0;
            ovf      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (go) begin
                        shreg    <= bin_in;
                        acc      <= '0;
                        ovf_cand <= over;
                        cnt      <= CNT_W'(BIN_W);
                        busy     <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Adjust is applied to the accumulator before the shift; digit carries ride the shift.
                    {acc, shreg} <= {acc_adj, shreg} << 1;
                    cnt          <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    bcd   <= ovf_cand ? {DIGITS{4'd9}} : acc;
                    ovf   <= ovf_cand;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
